// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for the RV32M execute unit: operands and controls in,
// M-op result, write controls and stall request out.
interface ex_muldiv_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic [DATA_W-1:0]  op1_i;
  logic [DATA_W-1:0]  op2_i;
  logic [31:0]        inst_i;
  logic               reg_we_i;
  logic [RADDR_W-1:0] reg_waddr_i;
  logic               flush_jump_i;

  logic               md_sel_o;
  logic [DATA_W-1:0]  md_result_o;
  logic               md_valid_o;
  logic               md_we_o;
  logic [RADDR_W-1:0] md_waddr_o;
  logic               stall_req_o;
  logic               md_busy_o;

  modport master (
    output op1_i, op2_i, inst_i, reg_we_i, reg_waddr_i, flush_jump_i,
    input  md_sel_o, md_result_o, md_valid_o, md_we_o, md_waddr_o,
           stall_req_o, md_busy_o
  );

  modport slave (
    input  op1_i, op2_i, inst_i, reg_we_i, reg_waddr_i, flush_jump_i,
    output md_sel_o, md_result_o, md_valid_o, md_we_o, md_waddr_o,
           stall_req_o, md_busy_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M execute unit: single-cycle multiply, iterative radix-2 restoring divide.
// Divide holds the pipeline via stall_req_o from first presentation until the DONE cycle.
module ex_muldiv #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ex_muldiv_if.slave md
);

  localparam int PW    = 2*DATA_W + 2;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] dvd_q;   // dividend, becomes the quotient as bits shift in
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              rem_sel_q;

  logic              sel;
  logic [2:0]        f3;
  logic              op1_sgn;
  logic              op2_sgn;
  logic              div_signed;
  logic              start;
  logic              op2_zero;
  logic              ovf;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;

  logic signed [DATA_W:0] ma;
  logic signed [DATA_W:0] mb;
  logic signed [PW-1:0]   prod;
  logic [DATA_W-1:0]      mul_res;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   rem_sub;
  logic              q_bit;
  logic [DATA_W-1:0] quot_out;
  logic [DATA_W-1:0] rem_out;
  logic [DATA_W-1:0] div_res;

  always_comb begin
    sel        = (md.inst_i[6:0] == 7'b0110011) && (md.inst_i[31:25] == 7'b0000001);
    f3         = md.inst_i[14:12];
    op1_sgn    = md.op1_i[DATA_W-1];
    op2_sgn    = md.op2_i[DATA_W-1];
    div_signed = !f3[0];
    start      = (state == IDLE) && sel && f3[2] && !md.flush_jump_i;
    op2_zero   = (md.op2_i == '0);
    ovf        = div_signed && (md.op1_i == {1'b1, {(DATA_W-1){1'b0}}}) && (md.op2_i == '1);
    abs1       = (div_signed && op1_sgn) ? (~md.op1_i + 1'b1) : md.op1_i;
    abs2       = (div_signed && op2_sgn) ? (~md.op2_i + 1'b1) : md.op2_i;
  end

  // MULH sign-extends both operands, MULHSU only op1, MUL/MULHU neither.
  always_comb begin
    ma      = {((f3[1:0] == 2'b01) || (f3[1:0] == 2'b10)) && op1_sgn, md.op1_i};
    mb      = {(f3[1:0] == 2'b01) && op2_sgn, md.op2_i};
    prod    = PW'(ma) * PW'(mb);
    mul_res = (f3[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    rem_sh   = {rem_q, dvd_q[DATA_W-1]};
    rem_sub  = rem_sh - {1'b0, dvs_q};
    q_bit    = !rem_sub[DATA_W];
    quot_out = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_out  = neg_r_q ? (~rem_q + 1'b1) : rem_q;
    div_res  = rem_sel_q ? rem_out : quot_out;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_sel_q <= f3[1];
            neg_q_q   <= div_signed && (op1_sgn != op2_sgn) && !op2_zero;
            neg_r_q   <= div_signed && op1_sgn;
            dvs_q     <= abs2;
            cnt_q     <= '0;
            // Special cases skip iteration; the DONE-stage sign fixup still applies.
            if (op2_zero) begin
              dvd_q <= '1;
              rem_q <= abs1;
              state <= DONE;
            end else if (ovf) begin
              dvd_q <= {1'b1, {(DATA_W-1){1'b0}}};
              rem_q <= '0;
              state <= DONE;
            end else begin
              dvd_q <= abs1;
              rem_q <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (md.flush_jump_i) begin
            state <= IDLE;
          end else begin
            rem_q <= q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
            dvd_q <= {dvd_q[DATA_W-2:0], q_bit};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W-1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    md.md_sel_o    = 1'b0;
    md.md_result_o = '0;
    md.md_valid_o  = 1'b0;
    md.md_we_o     = 1'b0;
    md.md_waddr_o  = '0;
    md.stall_req_o = 1'b0;
    md.md_busy_o   = 1'b0;
    if (!rst_i) begin
      md.md_sel_o   = sel;
      md.md_waddr_o = md.reg_waddr_i;
      md.md_busy_o  = (state != IDLE);
      case (state)
        IDLE: begin
          if (sel && !f3[2] && !md.flush_jump_i) begin
            md.md_valid_o  = 1'b1;
            md.md_result_o = mul_res;
          end else if (start) begin
            md.stall_req_o = 1'b1;
          end
        end
        BUSY: begin
          md.stall_req_o = !md.flush_jump_i;
        end
        DONE: begin
          if (!md.flush_jump_i) begin
            md.md_valid_o  = 1'b1;
            md.md_result_o = div_res;
          end
        end
        default: begin
          md.md_valid_o = 1'b0;
        end
      endcase
      md.md_we_o = md.reg_we_i && md.md_valid_o;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: multiply variants, divide latency and
// results, divide special cases, flush abort and asynchronous reset mid-divide.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_W(32), .RADDR_W(5)) bus ();

  ex_muldiv #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .md    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_inst(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd7, 7'b0110011};
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic we);
    bus.inst_i       = m_inst(f3);
    bus.op1_i        = a;
    bus.op2_i        = b;
    bus.reg_we_i     = we;
    bus.reg_waddr_i  = 5'd7;
    bus.flush_jump_i = 1'b0;
  endtask

  task automatic nop();
    bus.inst_i   = 32'h0000_0013;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    bus.reg_we_i = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(f3, a, b, 1'b1);
    #1;
    check({tag, " result"}, bus.md_result_o, exp);
    check({tag, " valid"}, 32'(bus.md_valid_o), 32'd1);
    check({tag, " stall"}, 32'(bus.stall_req_o), 32'd0);
    check({tag, " we"}, 32'(bus.md_we_o), 32'd1);
  endtask

  // Called just after a rising edge; returns just after the edge that retires DONE.
  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic we, input logic [31:0] exp,
                         input int exp_stall);
    int stalls;
    int guard;
    stalls = 0;
    guard  = 0;
    drive(f3, a, b, we);
    #4;
    while (bus.stall_req_o && guard < 100) begin
      check({tag, " no early valid"}, 32'(bus.md_valid_o), 32'd0);
      stalls++;
      guard++;
      @(posedge clk);
      #5;
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, " result"}, bus.md_result_o, exp);
    check({tag, " valid"}, 32'(bus.md_valid_o), 32'd1);
    check({tag, " we"}, 32'(bus.md_we_o), 32'(we));
    check({tag, " waddr"}, 32'(bus.md_waddr_o), 32'd7);
    @(posedge clk);
    #1;
    nop();
    #1;
    check({tag, " idle after"}, 32'(bus.md_busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
    #2;
    check("reset sel", 32'(bus.md_sel_o), 32'd0);
    check("reset valid", 32'(bus.md_valid_o), 32'd0);
    check("reset result", bus.md_result_o, 32'd0);
    check("reset busy", 32'(bus.md_busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_mul("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_mul("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_mul("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mul("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("MUL sel", 32'(bus.md_sel_o), 32'd1);

    bus.inst_i = 32'h0020_81B3;
    #1;
    check("nonM sel", 32'(bus.md_sel_o), 32'd0);
    check("nonM valid", 32'(bus.md_valid_o), 32'd0);
    check("nonM stall", 32'(bus.stall_req_o), 32'd0);
    check("nonM result", bus.md_result_o, 32'd0);
    @(posedge clk);
    #1;

    run_div("DIV -20/3", 3'b100, 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFA, 33);
    run_div("REM -20/3", 3'b110, 32'hFFFF_FFEC, 32'd3, 1'b0, 32'hFFFF_FFFE, 33);
    run_div("DIVU 100/7", 3'b101, 32'd100, 32'd7, 1'b1, 32'd14, 33);
    run_div("REMU 100/7", 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 33);
    run_div("DIVU 5/0", 3'b101, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1);
    run_div("REM 5/0", 3'b110, 32'd5, 32'd0, 1'b1, 32'd5, 1);
    run_div("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1);
    run_div("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1);

    // Flush on the 10th BUSY cycle.
    drive(3'b101, 32'd1000, 32'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("flush busy before", 32'(bus.md_busy_o), 32'd1);
    bus.flush_jump_i = 1'b1;
    #1;
    check("flush stall", 32'(bus.stall_req_o), 32'd0);
    check("flush valid", 32'(bus.md_valid_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_jump_i = 1'b0;
    nop();
    #1;
    check("flush idle", 32'(bus.md_busy_o), 32'd0);
    check("flush no valid", 32'(bus.md_valid_o), 32'd0);
    @(posedge clk);
    #1;
    run_div("DIVU 9/2", 3'b101, 32'd9, 32'd2, 1'b1, 32'd4, 33);

    // Asynchronous reset in the middle of a divide.
    drive(3'b100, 32'hFFFF_FFEC, 32'd3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rst busy before", 32'(bus.md_busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(bus.md_busy_o), 32'd0);
    check("rst stall", 32'(bus.stall_req_o), 32'd0);
    check("rst valid", 32'(bus.md_valid_o), 32'd0);
    check("rst result", bus.md_result_o, 32'd0);
    check("rst sel", 32'(bus.md_sel_o), 32'd0);
    check("rst we", 32'(bus.md_we_o), 32'd0);
    check("rst waddr", 32'(bus.md_waddr_o), 32'd0);
    nop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post rst idle", 32'(bus.md_busy_o), 32'd0);
    @(posedge clk);
    #1;
    run_div("REMU after rst", 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
